// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch->decode decoupling queue.
// Holds {PC+4, instruction} pairs in a DEPTH-entry circular buffer and
// presents the oldest entry to decode directly from storage registers.
// pc_write is the only combinational output and provides fetch backpressure.
// It is computed from registered occupancy, so a decode stall never reaches
// the PC combinationally except through the head-valid term.
// Optional feature macro: IFID_PERF_EN (stall/flush performance counters).
module if_id_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_4_in,
  input  logic [31:0] instr_in,
  input  logic        id_stall,
  input  logic        flush,
  output logic        pc_write,
  output logic        valid_out,
  output logic [31:0] pc_4_out,
  output logic [3:0]  pc_4_hi,
  output logic [31:0] instr_out,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc  [DEPTH];
  logic [31:0]   r_ins [DEPTH];

  logic w_valid;
  logic w_full;
  logic w_deq;
  logic w_enq;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_deq    = w_valid & ~id_stall;
  // count never exceeds DEPTH, so (count < DEPTH) is simply ~full
  assign pc_write = ~reset & (flush | ~w_full | w_deq);
  assign w_enq    = pc_write & ~flush;

  assign valid_out = w_valid;
  assign pc_4_out  = w_valid ? r_pc[r_rd_ptr]  : '0;
  assign instr_out = w_valid ? r_ins[r_rd_ptr] : NOP;
  assign pc_4_hi   = pc_4_out[31:28];

  // Queue pointers and occupancy; flush returns everything to the empty origin
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_deq) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; written at the tail on every accepted fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]  <= '0;
        r_ins[i] <= '0;
      end
    end else if (w_enq) begin
      r_pc[r_wr_ptr]  <= pc_4_in;
      r_ins[r_wr_ptr] <= instr_in;
    end
  end

`ifdef IFID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Performance counters: decode stalls on a valid head, and redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_valid && id_stall && !flush) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)                         r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_if_id_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_4_in = '0;
  logic [31:0] instr_in = '0;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic        pc_write;
  logic        valid_out;
  logic [31:0] pc_4_out;
  logic [3:0]  pc_4_hi;
  logic [31:0] instr_out;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  if_id_buffer #(.DEPTH(DEPTH), .NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_4_in(pc_4_in), .instr_in(instr_in),
    .id_stall(id_stall), .flush(flush), .pc_write(pc_write),
    .valid_out(valid_out), .pc_4_out(pc_4_out), .pc_4_hi(pc_4_hi),
    .instr_out(instr_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: a FIFO of {pc, instr} pairs plus two counters
  logic [63:0] mq[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  bit started = 0;

  function automatic logic exp_pcw();
    return !reset && (flush || mq.size() < DEPTH || (mq.size() > 0 && !id_stall));
  endfunction

  always @(posedge clk) begin
    bit deq, enq;
    started = 1;
    if (reset) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else if (flush) begin
      mq.delete();
      m_flush++;
    end else begin
      deq = (mq.size() > 0) && !id_stall;
      enq = exp_pcw();
      if (mq.size() > 0 && id_stall) m_stall++;
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({pc_4_in, instr_in});
    end
  end

  // Compare process: all outputs against the model, mid-cycle
  always @(negedge clk) begin
    logic [31:0] epc, eins;
    if (started) begin
      epc  = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      eins = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
      chk("valid_out", 32'(valid_out), 32'(mq.size() > 0));
      chk("pc_4_out",  pc_4_out,  epc);
      chk("pc_4_hi",   32'(pc_4_hi), 32'(epc[31:28]));
      chk("instr_out", instr_out, eins);
      chk("pc_write",  32'(pc_write), 32'(exp_pcw()));
`ifdef IFID_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`else
      chk("stall_cnt", stall_cnt, 32'h0);
      chk("flush_cnt", flush_cnt, 32'h0);
`endif
    end
  end

  // Apply one cycle's inputs, then advance past the rising edge
  task automatic set_in(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
    reset = r; pc_4_in = pc; instr_in = ins; id_stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl);
    set_in(r, pc, ins, st, fl);
    step();
  endtask

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;
  localparam logic [31:0] D = 32'hDDDD_0004;

  initial begin
    // 1: reset held two cycles
    set_in(1, 32'h10, A, 0, 0);
    #1 chk("lit_rst_pcw", 32'(pc_write), 32'h0);
    step();
    drive(1, 32'h10, A, 0, 0);
    chk("lit_rst_valid", 32'(valid_out), 32'h0);
    chk("lit_rst_instr", instr_out, 32'h0);
    chk("lit_rst_pc", pc_4_out, 32'h0);
    set_in(0, 32'h4, A, 0, 0);
    #1 chk("lit_rel_pcw", 32'(pc_write), 32'h1);

    // 2: streaming without stall, one-cycle latency
    step();
    chk("lit_s_pc4", pc_4_out, 32'h4);  chk("lit_s_A", instr_out, A);
    drive(0, 32'h8, B, 0, 0);
    chk("lit_s_pc8", pc_4_out, 32'h8);  chk("lit_s_B", instr_out, B);
    drive(0, 32'hC, C, 0, 0);
    chk("lit_s_pcC", pc_4_out, 32'hC);  chk("lit_s_C", instr_out, C);
    drive(0, 32'h0, 32'h0, 0, 1);
    chk("lit_fl_empty", 32'(valid_out), 32'h0);

    // 3: fill to full under stall
    drive(0, 32'h4, A, 1, 0);
    drive(0, 32'h8, B, 1, 0);
    set_in(0, 32'hC, C, 1, 0);
    #1 chk("lit_full_pcw", 32'(pc_write), 32'h0);
    chk("lit_full_head", instr_out, A);
    step();
    chk("lit_full_hold", instr_out, A);

    // 4: full with simultaneous enqueue and dequeue
    set_in(0, 32'hC, C, 0, 0);
    #1 chk("lit_fd_pcw", 32'(pc_write), 32'h1);
    step();
    chk("lit_fd_headB", instr_out, B);  chk("lit_fd_pc8", pc_4_out, 32'h8);
    drive(0, 32'h10, D, 0, 0);
    chk("lit_fd_headC", instr_out, C);  chk("lit_fd_pcC", pc_4_out, 32'hC);

    // 5: flush while full and stalled; the concurrent fetch is dropped
    drive(0, 32'h0, 32'h0, 0, 1);
    drive(0, 32'h4, A, 1, 0);
    drive(0, 32'h8, B, 1, 0);
    set_in(0, 32'h44, D, 1, 1);
    #1 chk("lit_flush_pcw", 32'(pc_write), 32'h1);
    step();
    chk("lit_flush_valid", 32'(valid_out), 32'h0);
    chk("lit_flush_instr", instr_out, 32'h0);
    drive(0, 32'h48, C, 0, 0);
    chk("lit_redirect_pc", pc_4_out, 32'h48);

    // 6: performance counters from a fresh reset
    drive(1, 32'h0, 32'h0, 0, 0);
    drive(0, 32'h4, A, 0, 0);
    repeat (3) drive(0, 32'h8, B, 1, 0);
    drive(0, 32'hC, C, 0, 1);
`ifdef IFID_PERF_EN
    chk("lit_stall_cnt", stall_cnt, 32'd3);
    chk("lit_flush_cnt", flush_cnt, 32'd1);
`else
    chk("lit_stall_cnt", stall_cnt, 32'd0);
    chk("lit_flush_cnt", flush_cnt, 32'd0);
`endif

    // Mixed stall/flush pattern, checked by the model each cycle
    for (int i = 0; i < 48; i++) begin
      drive(0, 32'h1000_0000 * (i % 16) + 32'(4 * i), 32'hA000_0000 + 32'(i),
            (i % 3 == 0) || (i % 7 < 2), (i % 11 == 7));
    end
    drive(0, 32'h0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
